instr_fetch_unit: RTL and testbench

//  Initiator side of the instruction-memory read interface. Owns the PC and issues

---
 rtl/ifu_pkg.sv | 28 ++
 rtl/fetch_buf.sv | 56 +++++
 rtl/instr_fetch_unit.sv | 135 +++++++++++++
 tb/tb_instr_fetch_unit.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifu_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// ifu_pkg - state codes, entry type and constants for instr_fetch_unit
// Revision: 1.0
// ------------------------------------------------------------------
package ifu_pkg;

  localparam int IMEM_AW = 16;
  localparam int INSTR_W = 16;
  localparam logic [3:0] OPC_HLT = 4'hF;

  typedef logic [1:0] ifu_state_t;
  localparam ifu_state_t IDLE  = 2'd0;
  localparam ifu_state_t REQ   = 2'd1;
  localparam ifu_state_t DRAIN = 2'd2;
  localparam ifu_state_t HALT  = 2'd3;

  typedef struct packed {
    logic [IMEM_AW-1:0] pc;
    logic [INSTR_W-1:0] instr;
  } fbuf_entry_t;

  function automatic logic is_hlt(input logic [INSTR_W-1:0] word);
    return word[INSTR_W-1 -: 4] == OPC_HLT;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_buf.sv
`default_nettype none
// ------------------------------------------------------------------
// fetch_buf - synchronous FIFO of {pc,instr} between fetch and decode
// Revision: 1.0
// ------------------------------------------------------------------
module fetch_buf
  import ifu_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic                    push,
  input  logic                    pop,
  input  fbuf_entry_t             push_data,
  output fbuf_entry_t             head,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1);

  fbuf_entry_t   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // Depth is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if (push && !pop)      count <= count + CNT_ONE;
      else if (pop && !push) count <= count - CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_data;
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);

endmodule
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ------------------------------------------------------------------
// instr_fetch_unit - PC owner, I-memory read initiator and fetch buffer.
// Optional HLT detection: define IFU_HALT_DETECT_EN.  Revision: 1.0
// ------------------------------------------------------------------
module instr_fetch_unit
  import ifu_pkg::*;
#(
  parameter logic [IMEM_AW-1:0] RESET_PC   = 16'h0000,
  parameter int                 FBUF_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [IMEM_AW-1:0] im_addr,
  output logic               im_rd_en,
  input  logic [INSTR_W-1:0] im_instr,
  input  logic               im_vld,
  output logic [INSTR_W-1:0] if_instr,
  output logic [IMEM_AW-1:0] if_pc,
  output logic               if_vld,
  input  logic               id_rdy,
  input  logic               redirect,
  input  logic [IMEM_AW-1:0] redirect_pc,
  output logic               halted
);

  localparam int CW = $clog2(FBUF_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FBUF_DEPTH);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [IMEM_AW-1:0] PC_ONE = IMEM_AW'(1);

  ifu_state_t         state;
  ifu_state_t         state_nx;
  logic [IMEM_AW-1:0] fpc;
  logic [IMEM_AW-1:0] drain_addr;
  logic [CW-1:0]      count;
  logic [CW-1:0]      count_nx;
  logic               buf_empty;
  logic               push;
  logic               pop;
  logic               hlt_push;
  fbuf_entry_t        push_data;
  fbuf_entry_t        head;

  assign im_rd_en = (state == REQ) || (state == DRAIN);
  // While draining, fpc already holds the redirect target; the stale address stays on the bus.
  assign im_addr  = (state == DRAIN) ? drain_addr : fpc;

  assign if_vld   = !buf_empty;
  assign if_instr = head.instr;
  assign if_pc    = head.pc;

  assign pop       = if_vld & id_rdy & ~redirect;
  assign push      = (state == REQ) & im_vld & ~redirect;
  assign push_data = '{pc: fpc, instr: im_instr};

  always_comb begin
    count_nx = count;
    if (push) count_nx = count_nx + CNT_ONE;
    if (pop)  count_nx = count_nx - CNT_ONE;
  end

`ifdef IFU_HALT_DETECT_EN
  assign hlt_push = push & is_hlt(im_instr);
`else
  assign hlt_push = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    if (redirect) begin
      state_nx = (im_rd_en && !im_vld) ? DRAIN : REQ;
    end else begin
      case (state)
        IDLE:    if (count_nx < DEPTH_C) state_nx = REQ;
        REQ: begin
          if (im_vld) begin
            if (hlt_push)                 state_nx = HALT;
            else if (count_nx == DEPTH_C) state_nx = IDLE;
          end
        end
        DRAIN:   if (im_vld) state_nx = REQ;
        HALT:    state_nx = HALT;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      fpc        <= RESET_PC;
      drain_addr <= RESET_PC;
    end else begin
      state <= state_nx;
      if (redirect) begin
        fpc <= redirect_pc;
        if (state == REQ && !im_vld) drain_addr <= fpc;
      end else if (push) begin
        fpc <= fpc + PC_ONE;
      end
    end
  end

`ifdef IFU_HALT_DETECT_EN
  logic halted_q;

  // halted rises once the HLT word itself has left the buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                  halted_q <= 1'b0;
    else if (redirect)                           halted_q <= 1'b0;
    else if (state == HALT && count_nx == '0)    halted_q <= 1'b1;
  end

  assign halted = halted_q;
`else
  assign halted = 1'b0;
`endif

  fetch_buf #(
    .DEPTH (FBUF_DEPTH)
  ) u_fetch_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect),
    .push      (push),
    .pop       (pop),
    .push_data (push_data),
    .head      (head),
    .empty     (buf_empty),
    .count     (count)
  );

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_instr_fetch_unit - vector table, corner sequences and a random run
// Revision: 1.0
// ------------------------------------------------------------------
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] im_addr;
  logic        im_rd_en;
  logic [15:0] im_instr;
  logic        im_vld;
  logic [15:0] if_instr;
  logic [15:0] if_pc;
  logic        if_vld;
  logic        id_rdy = 1'b1;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;
  logic        halted;

  always #5 clk = ~clk;

  instr_fetch_unit #(
    .RESET_PC   (16'h0000),
    .FBUF_DEPTH (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .im_addr     (im_addr),
    .im_rd_en    (im_rd_en),
    .im_instr    (im_instr),
    .im_vld      (im_vld),
    .if_instr    (if_instr),
    .if_pc       (if_pc),
    .if_vld      (if_vld),
    .id_rdy      (id_rdy),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .halted      (halted)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Memory model: programmed words at 0..4, optional HLT at 0x10, per-address latency.
  logic        hlt_on = 1'b0;
  logic        miss_on = 1'b0;
  logic        rand_lat = 1'b0;
  logic [15:0] miss_addr = 16'h0000;
  int          miss_lat = 0;
  int          age = 0;

  function automatic logic [15:0] memf(input logic [15:0] a, input logic hlt);
    if (hlt && a == 16'h0010) return 16'hF000;
    case (a)
      16'h0000: return 16'hB101;
      16'h0001: return 16'hA100;
      16'h0002: return 16'hB210;
      16'h0003: return 16'hA200;
      16'h0004: return 16'h1011;
      default:  return {1'b0, a[14:12] ^ a[2:0], a[11:0] ^ a[15:4]};
    endcase
  endfunction

  function automatic int lat_for(input logic [15:0] a, input logic mon, input logic [15:0] ma,
                                 input int ml, input logic rl);
    logic [15:0] h;
    if (mon && a == ma) return ml;
    h = (a * 16'd37) >> 5;
    if (rl) return int'(h[1:0]);
    return 0;
  endfunction

  always_comb begin
    im_vld   = im_rd_en && (age >= lat_for(im_addr, miss_on, miss_addr, miss_lat, rand_lat));
    im_instr = memf(im_addr, hlt_on);
  end

  always @(posedge clk) age <= (im_rd_en && !im_vld) ? age + 1 : 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // An outstanding request must keep im_rd_en and im_addr steady until im_vld.
  logic        prev_out = 1'b0;
  logic [15:0] prev_addr = 16'h0000;
  always @(negedge clk) begin
    if (rst_n && prev_out) begin
      chk("hold_rd_en", {31'd0, im_rd_en}, 32'd1);
      chk("hold_addr", {16'd0, im_addr}, {16'd0, prev_addr});
    end
    prev_out  = rst_n && im_rd_en && !im_vld;
    prev_addr = im_addr;
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    id_rdy = 1'b1;
    redirect = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
  endtask

  task automatic wait_req(input logic [15:0] a, input string name);
    logic found = 1'b0;
    for (int w = 0; w < 100 && !found; w++) begin
      if (im_rd_en && im_addr == a) found = 1'b1;
      else step();
    end
    chk(name, {31'd0, found}, 32'd1);
  endtask

  task automatic expect_pops(input logic [15:0] start, input int n, input string name);
    logic [15:0] pc = start;
    for (int w = 0; w < 100 && !if_vld; w++) step();
    for (int i = 0; i < n; i++) begin
      chk({name, "_vld"}, {31'd0, if_vld}, 32'd1);
      chk({name, "_pc"}, {16'd0, if_pc}, {16'd0, pc});
      chk({name, "_instr"}, {16'd0, if_instr}, {16'd0, memf(pc, hlt_on)});
      pc = pc + 16'd1;
      step();
    end
  endtask

  typedef struct {
    logic        id_rdy;
    logic        exp_rd_en;
    logic [15:0] exp_addr;
    logic        exp_vld;
    logic [15:0] exp_pc;
  } vec_t;

  vec_t        vecs[17];
  logic [15:0] exp_pc;
  int          n_pops;

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Zero-wait fetch from reset, then a 6-cycle decode stall and recovery.
    vecs[0]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000};
    vecs[1]  = '{1'b1, 1'b1, 16'h0000, 1'b0, 16'h0000};
    vecs[2]  = '{1'b1, 1'b1, 16'h0001, 1'b1, 16'h0000};
    vecs[3]  = '{1'b1, 1'b1, 16'h0002, 1'b1, 16'h0001};
    vecs[4]  = '{1'b1, 1'b1, 16'h0003, 1'b1, 16'h0002};
    vecs[5]  = '{1'b1, 1'b1, 16'h0004, 1'b1, 16'h0003};
    vecs[6]  = '{1'b1, 1'b1, 16'h0005, 1'b1, 16'h0004};
    vecs[7]  = '{1'b0, 1'b1, 16'h0006, 1'b1, 16'h0005};
    vecs[8]  = '{1'b0, 1'b0, 16'h0007, 1'b1, 16'h0005};
    vecs[9]  = '{1'b0, 1'b0, 16'h0007, 1'b1, 16'h0005};
    vecs[10] = '{1'b0, 1'b0, 16'h0007, 1'b1, 16'h0005};
    vecs[11] = '{1'b0, 1'b0, 16'h0007, 1'b1, 16'h0005};
    vecs[12] = '{1'b0, 1'b0, 16'h0007, 1'b1, 16'h0005};
    vecs[13] = '{1'b1, 1'b0, 16'h0007, 1'b1, 16'h0005};
    vecs[14] = '{1'b1, 1'b1, 16'h0007, 1'b1, 16'h0006};
    vecs[15] = '{1'b1, 1'b1, 16'h0008, 1'b1, 16'h0007};
    vecs[16] = '{1'b1, 1'b1, 16'h0009, 1'b1, 16'h0008};

    do_reset();
    chk("reset_halted", {31'd0, halted}, 32'd0);
    for (int i = 0; i < 17; i++) begin
      if (i > 0) step();
      id_rdy = vecs[i].id_rdy;
      chk($sformatf("vec%0d_rd_en", i), {31'd0, im_rd_en}, {31'd0, vecs[i].exp_rd_en});
      chk($sformatf("vec%0d_addr", i), {16'd0, im_addr}, {16'd0, vecs[i].exp_addr});
      chk($sformatf("vec%0d_vld", i), {31'd0, if_vld}, {31'd0, vecs[i].exp_vld});
      if (vecs[i].exp_vld) begin
        chk($sformatf("vec%0d_pc", i), {16'd0, if_pc}, {16'd0, vecs[i].exp_pc});
        chk($sformatf("vec%0d_instr", i), {16'd0, if_instr},
            {16'd0, memf(vecs[i].exp_pc, 1'b0)});
      end
    end

    // Five-cycle miss at 0x0007.
    miss_on = 1'b1; miss_addr = 16'h0007; miss_lat = 5;
    do_reset();
    wait_req(16'h0007, "miss_req_seen");
    for (int k = 0; k < 5; k++) begin
      chk("miss_hold_rd_en", {31'd0, im_rd_en}, 32'd1);
      chk("miss_hold_addr", {16'd0, im_addr}, 32'h0007);
      chk("miss_no_vld", {31'd0, im_vld}, 32'd0);
      step();
    end
    chk("miss_vld", {31'd0, im_vld}, 32'd1);
    step();
    chk("miss_if_vld", {31'd0, if_vld}, 32'd1);
    chk("miss_if_pc", {16'd0, if_pc}, 32'h0007);
    chk("miss_if_instr", {16'd0, if_instr}, {16'd0, memf(16'h0007, 1'b0)});

    // Asynchronous reset while a request is outstanding.
    miss_addr = 16'h000A; miss_lat = 20;
    wait_req(16'h000A, "areset_req_seen");
    step();
    rst_n = 1'b0;
    #1;
    chk("areset_rd_en", {31'd0, im_rd_en}, 32'd0);
    chk("areset_if_vld", {31'd0, if_vld}, 32'd0);
    chk("areset_addr", {16'd0, im_addr}, 32'h0000);

    // Redirect to 0x000C during a miss at 0x0008.
    miss_addr = 16'h0008; miss_lat = 5;
    do_reset();
    wait_req(16'h0008, "drain_req_seen");
    step();
    redirect = 1'b1; redirect_pc = 16'h000C;
    step();
    redirect = 1'b0;
    chk("drain_buf_empty", {31'd0, if_vld}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      chk("drain_rd_en", {31'd0, im_rd_en}, 32'd1);
      chk("drain_addr", {16'd0, im_addr}, 32'h0008);
      step();
    end
    chk("drain_vld", {31'd0, im_vld}, 32'd1);
    step();
    chk("drain_next_addr", {16'd0, im_addr}, 32'h000C);
    chk("drain_next_rd_en", {31'd0, im_rd_en}, 32'd1);
    chk("drain_still_empty", {31'd0, if_vld}, 32'd0);
    expect_pops(16'h000C, 3, "drain_pops");
    miss_on = 1'b0;

    // Redirect in the same cycle as im_vld.
    do_reset();
    wait_req(16'h0003, "samecyc_req_seen");
    chk("samecyc_vld", {31'd0, im_vld}, 32'd1);
    redirect = 1'b1; redirect_pc = 16'h0020;
    step();
    redirect = 1'b0;
    chk("samecyc_addr", {16'd0, im_addr}, 32'h0020);
    chk("samecyc_rd_en", {31'd0, im_rd_en}, 32'd1);
    chk("samecyc_empty", {31'd0, if_vld}, 32'd0);
    expect_pops(16'h0020, 3, "samecyc_pops");

    // PC wrap FFFF -> 0000.
    redirect = 1'b1; redirect_pc = 16'hFFFE;
    step();
    redirect = 1'b0;
    expect_pops(16'hFFFE, 4, "wrap_pops");

    // HLT word at 0x0010.
    hlt_on = 1'b1;
    redirect = 1'b1; redirect_pc = 16'h000E;
    step();
    redirect = 1'b0;
`ifdef IFU_HALT_DETECT_EN
    expect_pops(16'h000E, 3, "hlt_pops");
    chk("hlt_halted", {31'd0, halted}, 32'd1);
    chk("hlt_empty", {31'd0, if_vld}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      chk("hlt_no_req", {31'd0, im_rd_en}, 32'd0);
      step();
    end
    chk("hlt_still_halted", {31'd0, halted}, 32'd1);
    redirect = 1'b1; redirect_pc = 16'h0000;
    step();
    redirect = 1'b0;
    chk("hlt_resume_halted", {31'd0, halted}, 32'd0);
    chk("hlt_resume_rd_en", {31'd0, im_rd_en}, 32'd1);
    chk("hlt_resume_addr", {16'd0, im_addr}, 32'h0000);
    expect_pops(16'h0000, 2, "hlt_resume_pops");
`else
    expect_pops(16'h000E, 4, "hlt_plain_pops");
    chk("hlt_plain_halted", {31'd0, halted}, 32'd0);
`endif
    hlt_on = 1'b0;

    // Random decode stalls, latencies and redirects against an in-order PC stream model.
    rand_lat = 1'b1;
    do_reset();
    exp_pc = 16'h0000;
    n_pops = 0;
    for (int c = 0; c < 3000; c++) begin
      step();
      id_rdy = ($urandom_range(0, 9) < 7);
      redirect = ($urandom_range(0, 99) < 3);
      redirect_pc = 16'($urandom);
      if (redirect) begin
        exp_pc = redirect_pc;
      end else if (if_vld && id_rdy) begin
        chk("rand_pc", {16'd0, if_pc}, {16'd0, exp_pc});
        chk("rand_instr", {16'd0, if_instr}, {16'd0, memf(exp_pc, 1'b0)});
        exp_pc = exp_pc + 16'd1;
        n_pops++;
      end
    end
    redirect = 1'b0;
    chk("rand_liveness", {31'd0, n_pops > 300}, 32'd1);
    chk("rand_halted", {31'd0, halted}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
